vga_scanout: RTL and testbench

//  Parametrised VGA scan-out engine: timing generator + framebuffer fetch + pixel/sync output.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_axis_counter.sv | 25 ++
 rtl/vga_scanout.sv | 113 +++++++++++
 tb/tb_vga_scanout.sv | 130 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: region encoding, default 640x480@60 timing and the axis-length helper shared by the scan-out engine
package vga_pkg;
  typedef enum logic [1:0] {
    STATE_VISIBLE     = 2'd0,
    STATE_FRONT_PORCH = 2'd1,
    STATE_SYNC        = 2'd2,
    STATE_BACK_PORCH  = 2'd3
  } region_t;
  localparam int COUNT_W       = 16;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  function automatic int axis_total(input int visible, input int front, input int sync, input int back);
    return visible + front + sync + back;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis -- position counter with wrap strobe and visible/porch/sync region decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic               i_Clock,
  input  logic               clear,
  input  logic               inc,
  output logic [COUNT_W-1:0] count,
  output region_t            region,
  output logic               wrap
);
  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
  assign wrap = inc && count == COUNT_W'(TOTAL - 1);
  always_ff @(posedge i_Clock)
    count <= (clear || wrap) ? '0 : inc ? count + COUNT_W'(1) : count;
  always_comb
    region = count < COUNT_W'(VISIBLE)                ? STATE_VISIBLE :
             count < COUNT_W'(VISIBLE + FRONT)        ? STATE_FRONT_PORCH :
             count < COUNT_W'(VISIBLE + FRONT + SYNC) ? STATE_SYNC : STATE_BACK_PORCH;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator, framebuffer fetch and latency-aligned pixel/sync output
// Define VGA_TEST_PATTERN_EN to add i_Pattern_Sel, which swaps the framebuffer for x[5:3] colour bars.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int BITS_PER_PIXEL  = 3,
  parameter int CLOCK_DIVIDE    = 4,
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit H_SYNC_POL      = 1'b0,
  parameter bit V_SYNC_POL      = 1'b0,
  parameter int FB_READ_LATENCY = 1
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Enable,
  input  logic [BITS_PER_PIXEL-1:0] i_Fb_Read_Data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                      i_Pattern_Sel,
`endif
  output logic [31:0]               o_Fb_Read_Addr,
  output logic                      o_Fb_Read_En,
  output logic [BITS_PER_PIXEL-1:0] o_RGB,
  output logic                      o_Horizontal_Sync,
  output logic                      o_Vertical_Sync,
  output logic                      o_Frame_Start,
  output logic                      o_Vblank
);
  localparam int DIV_W = CLOCK_DIVIDE > 1 ? $clog2(CLOCK_DIVIDE) : 1;
  logic                      clear, tick, h_wrap, v_wrap, visible, frame_first;
  logic                      vis_d, hs_d, vs_d, fs_d;
  logic [DIV_W-1:0]          div;
  logic [COUNT_W-1:0]        h_count, v_count;
  region_t                   h_region, v_region;
  logic [31:0]               addr;
  logic [BITS_PER_PIXEL-1:0] px;
  // a dropped enable is treated exactly like reset, so both share one clear
  assign clear = i_Reset | ~i_Enable;
  assign tick  = div == '0;
  always_ff @(posedge i_Clock)
    div <= (clear || div == DIV_W'(CLOCK_DIVIDE - 1)) ? '0 : div + DIV_W'(1);
  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .i_Clock(i_Clock), .clear(clear), .inc(tick),
    .count(h_count), .region(h_region), .wrap(h_wrap)
  );
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .i_Clock(i_Clock), .clear(clear), .inc(h_wrap),
    .count(v_count), .region(v_region), .wrap(v_wrap)
  );
  assign visible     = h_region == STATE_VISIBLE && v_region == STATE_VISIBLE;
  assign frame_first = tick && h_count == '0 && v_count == '0;
  // running address replaces y*H_VISIBLE+x; it already points at the next line's start during h-blank
  always_ff @(posedge i_Clock)
    if (clear || v_wrap) addr <= '0;
    else if (tick && visible) addr <= addr + 32'd1;
  assign o_Fb_Read_Addr = addr;
  assign o_Vblank       = v_region != STATE_VISIBLE;
`ifdef VGA_TEST_PATTERN_EN
  localparam int SW = 8;
  logic       sel_d;
  logic [2:0] bar_d;
  logic [SW-1:0] stage_in, stage_out;
  assign o_Fb_Read_En = ~clear & tick & visible & ~i_Pattern_Sel;
  assign stage_in = {i_Pattern_Sel, h_count[5:3], frame_first, v_region == STATE_SYNC,
                     h_region == STATE_SYNC, visible};
  assign {sel_d, bar_d, fs_d, vs_d, hs_d, vis_d} = stage_out;
  assign px = sel_d ? BITS_PER_PIXEL'(bar_d) : i_Fb_Read_Data;
`else
  localparam int SW = 4;
  logic [SW-1:0] stage_in, stage_out;
  assign o_Fb_Read_En = ~clear & tick & visible;
  assign stage_in = {frame_first, v_region == STATE_SYNC, h_region == STATE_SYNC, visible};
  assign {fs_d, vs_d, hs_d, vis_d} = stage_out;
  assign px = i_Fb_Read_Data;
`endif
  // control flags ride alongside the framebuffer read so they land with its data
  generate
    if (FB_READ_LATENCY == 0) begin : g_nodly
      assign stage_out = stage_in;
    end else begin : g_dly
      logic [SW-1:0] pipe [FB_READ_LATENCY];
      always_ff @(posedge i_Clock)
        if (clear) pipe <= '{default: '0};
        else begin
          pipe[0] <= stage_in;
          for (int i = 1; i < FB_READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      assign stage_out = pipe[FB_READ_LATENCY-1];
    end
  endgenerate
  always_ff @(posedge i_Clock)
    if (clear) begin
      o_RGB             <= '0;
      o_Horizontal_Sync <= ~H_SYNC_POL;
      o_Vertical_Sync   <= ~V_SYNC_POL;
      o_Frame_Start     <= 1'b0;
    end else begin
      o_RGB             <= vis_d ? px : '0;
      o_Horizontal_Sync <= hs_d ? H_SYNC_POL : ~H_SYNC_POL;
      o_Vertical_Sync   <= vs_d ? V_SYNC_POL : ~V_SYNC_POL;
      o_Frame_Start     <= fs_d;
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: small-timing scan-out bench; a position model derived from elapsed ticks checks every cycle
module tb_vga_scanout;
  localparam int HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int CD = 2, LAT = 2;
  localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT * CD;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1, pat = 1'b0;
  logic [2:0]  fb_data, m1, m2, rgb;
  logic [31:0] addr;
  logic        fb_en, hs, vs, fs, vb;
  int          k = 0, errors = 0, checks = 0, hs_low = 0, vs_low = 0;
  bit          armed = 1'b0;
  always #5 clk = ~clk;
  vga_scanout #(
    .BITS_PER_PIXEL(3), .CLOCK_DIVIDE(CD),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .FB_READ_LATENCY(LAT)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Enable(en), .i_Fb_Read_Data(fb_data),
`ifdef VGA_TEST_PATTERN_EN
    .i_Pattern_Sel(pat),
`endif
    .o_Fb_Read_Addr(addr), .o_Fb_Read_En(fb_en), .o_RGB(rgb),
    .o_Horizontal_Sync(hs), .o_Vertical_Sync(vs), .o_Frame_Start(fs), .o_Vblank(vb)
  );
  // framebuffer holding addr[2:0] at every address, answering LAT cycles after the address
  always @(posedge clk) begin
    m1 <= addr[2:0];
    m2 <= m1;
  end
  assign fb_data = m2;
  // k = cycles since the last edge that saw reset or a low enable
  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    k <= (rst || !en) ? 0 : k + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%0h expected=%0h", name, k, act, exp);
    end
  endtask
  // counters at cycle j have seen one tick per CD cycles, ticks landing on j=0,CD,2CD..
  function automatic void pos(input int j, output int x, output int y);
    int p;
    p = ((j + CD - 1) / CD) % (HT * VT);
    x = p % HT;
    y = p / HT;
  endfunction
  always @(negedge clk) if (armed) begin : cmp
    int x, y, jx, jy;
    bit vis_now, vis_d;
    logic [2:0] rgb_e;
    pos(k, x, y);
    vis_now = x < HV && y < VV;
    chk("fb_en", fb_en, en && !rst && !pat && k % CD == 0 && vis_now);
    if (en && !rst && k % CD == 0 && vis_now) chk("addr", addr, y * HV + x);
    if (k == 0) chk("addr_clear", addr, 0);
    chk("vblank", vb, y >= VV);
    if (k >= LAT + 1) begin
      pos(k - LAT - 1, jx, jy);
      vis_d = jx < HV && jy < VV;
      rgb_e = vis_d ? (pat ? 3'((jx >> 3) & 7) : 3'((jy * HV + jx) % 8)) : 3'd0;
      chk("rgb", rgb, rgb_e);
      chk("hsync", hs, !(jx >= HV + HF && jx < HV + HF + HS));
      chk("vsync", vs, !(jy >= VV + VF && jy < VV + VF + VS));
      chk("frame_start", fs, (k - LAT - 1) % FRAME == 0);
    end else begin
      chk("rgb_idle", rgb, 0);
      chk("hsync_idle", hs, 1);
      chk("vsync_idle", vs, 1);
      chk("frame_start_idle", fs, 0);
    end
    if (k == 98) chk("addr_line3_px7", addr, 31);
    if (k == 196) chk("addr_next_frame", addr, 0);
    if (k == LAT + 1) chk("frame_start_first", fs, 1);
    if (k == LAT + 1) begin
      hs_low = int'(!hs);
      vs_low = int'(!vs);
    end else if (k > LAT + 1 && k < LAT + 1 + FRAME) begin
      hs_low += int'(!hs);
      vs_low += int'(!vs);
    end
    if (k == LAT + 1 + FRAME) begin
      chk("hsync_low_cycles_per_frame", hs_low, 28);
      chk("vsync_low_cycles_per_frame", vs_low, 28);
      chk("frame_start_period", fs, 1);
    end
  end
  initial begin
    int g;
    rst = 1'b1;
    en  = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * FRAME + 20) @(posedge clk);
    g = 0;
    while (k % FRAME != 60 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 1000) begin
      errors++;
      $display("FAIL wait_line2 k=%0d got=timeout expected=line 2", k);
    end
    @(posedge clk);
    #1 en = 1'b0;
    repeat (8) @(posedge clk);
    #1 en = 1'b1;
    repeat (FRAME + 40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (FRAME + 10) @(posedge clk);
`ifdef VGA_TEST_PATTERN_EN
    #1 rst = 1'b1;
    pat = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (FRAME + 10) @(posedge clk);
`endif
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
